// File: rtl/me_protocol_monitor.sv
// Protocol monitor for the motion-estimation trigger/done handshake.
// Flags ordering, timeout, vector-range and result-stability violations and tracks search latency.
module me_protocol_monitor #(
    parameter int DIST_W    = 8,
    parameter int VEC_W     = 4,
    parameter int RANGE_MIN = -8,
    parameter int RANGE_MAX = 7,
    parameter int MAX_LAT   = 4096,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              trigger,
    input  logic              done,
    input  logic [DIST_W-1:0] distance,
    input  logic [VEC_W-1:0]  vector_x,
    input  logic [VEC_W-1:0]  vector_y,
    input  logic              clear,
    output logic              busy,
    output logic [4:0]        err_flags,
    output logic              err_any,
    output logic [CNT_W-1:0]  err_count,
    output logic [CNT_W-1:0]  last_latency,
    output logic [CNT_W-1:0]  max_latency,
    output logic [CNT_W-1:0]  result_count
);

    localparam int CMP_W = (VEC_W > 32) ? VEC_W : 32;
    localparam logic signed [CMP_W-1:0] RMIN = CMP_W'(RANGE_MIN);
    localparam logic signed [CMP_W-1:0] RMAX = CMP_W'(RANGE_MAX);
    localparam logic [CNT_W-1:0] LAT_LIMIT = CNT_W'(MAX_LAT);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] SAT       = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_RUN,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic                done_q;
    logic [CNT_W-1:0]    lat_cnt;
    logic [DIST_W-1:0]   cap_dist;
    logic [VEC_W-1:0]    cap_x, cap_y;

    logic                done_rise, run_rise, lat_at_limit;
    logic signed [CMP_W-1:0] vx_s, vy_s;
    logic                vec_bad;
    logic [4:0]          err_vec, flags_d;
    logic                fire;
    logic [CNT_W-1:0]    err_count_d, max_base, max_d, rc_base, rc_d;

    assign done_rise    = done && !done_q;
    assign run_rise     = (state_q == S_RUN) && done_rise;
    assign lat_at_limit = (lat_cnt == LAT_LIMIT);
    assign busy         = (state_q == S_ARMED) || (state_q == S_RUN);

    // Sign-extend to at least 32 bits so RANGE extremes compare without overflow.
    assign vx_s    = CMP_W'(signed'(vector_x));
    assign vy_s    = CMP_W'(signed'(vector_y));
    assign vec_bad = (vx_s < RMIN) || (vx_s > RMAX) || (vy_s < RMIN) || (vy_s > RMAX);

    // NOTE: every signal written in an always_comb gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (trigger) state_d = S_ARMED;
            S_ARMED: if (!trigger) state_d = S_RUN;
            S_RUN: begin
                if (done_rise)         state_d = S_DONE;
                else if (trigger)      state_d = S_ARMED;
                else if (lat_at_limit) state_d = S_IDLE;
            end
            S_DONE: begin
                if (trigger)    state_d = S_ARMED;
                else if (!done) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        err_vec    = '0;
        err_vec[0] = trigger && done;
        err_vec[1] = (state_q == S_RUN) && !done_rise && !trigger && lat_at_limit;
        err_vec[2] = run_rise && vec_bad;
        err_vec[3] = done_rise && ((state_q == S_IDLE) || (state_q == S_ARMED));
        err_vec[4] = (state_q == S_DONE) && done && !trigger &&
                     ((distance != cap_dist) || (vector_x != cap_x) || (vector_y != cap_y));
        fire       = |err_vec;
    end

    // clear is applied before any error raised in the same cycle.
    always_comb begin
        flags_d     = (clear ? 5'b0 : err_flags) | err_vec;
        err_count_d = err_count;
        if (clear)
            err_count_d = fire ? ONE : '0;
        else if (fire && (err_count != SAT))
            err_count_d = err_count + ONE;

        max_base = clear ? '0 : max_latency;
        max_d    = max_base;
        if (run_rise && (lat_cnt > max_base))
            max_d = lat_cnt;

        rc_base = clear ? '0 : result_count;
        rc_d    = rc_base;
        if (run_rise && (rc_base != SAT))
            rc_d = rc_base + ONE;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            done_q       <= 1'b0;
            lat_cnt      <= '0;
            cap_dist     <= '0;
            cap_x        <= '0;
            cap_y        <= '0;
            err_flags    <= '0;
            err_any      <= 1'b0;
            err_count    <= '0;
            last_latency <= '0;
            max_latency  <= '0;
            result_count <= '0;
        end else begin
            state_q      <= state_d;
            done_q       <= done;
            err_flags    <= flags_d;
            err_any      <= |flags_d;
            err_count    <= err_count_d;
            max_latency  <= max_d;
            result_count <= rc_d;

            if ((state_q == S_ARMED) && !trigger)
                lat_cnt <= ONE;
            else if ((state_q == S_RUN) && (lat_cnt != SAT))
                lat_cnt <= lat_cnt + ONE;

            if (run_rise) begin
                last_latency <= lat_cnt;
                cap_dist     <= distance;
                cap_x        <= vector_x;
                cap_y        <= vector_y;
            end
        end
    end

endmodule
